reduce_and_checker: RTL and testbench

REDUCE_AND_CHECKER -- requirements
Module: reduce_and_checker

---
 rtl/reduce_and_checker.sv | 165 ++++++++++++++++
 tb/tb_reduce_and_checker.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reduce_and_checker.sv
// ---------------------------------------------------------------------------
// reduce_and_checker
//
// Purpose: scoreboard for a WIDTH-input reduce-AND device. Between a start
// pulse and a stop pulse, every valid sample (in_vec, in_out) is compared
// against &in_vec. The block counts samples and mismatches, captures the
// first failing vector, and produces a pass/fail verdict when the run ends.
//
// Parameters:
//    WIDTH          width of the observed input vector
//    CNT_W          width of the sample and error counters (saturating)
//
// Ports:
//    clk            clock, all state changes on the rising edge
//    rst            synchronous active-high reset
//    start          pulse: begin a run (honoured in IDLE and DONE)
//    stop           pulse: end a run (honoured in RUN)
//    in_valid       in_vec/in_out carry a sample this cycle
//    in_vec         vector applied to the device under test
//    in_out         reduce-AND result observed from the device under test
//    busy           high while a run is active
//    done           high once a run has ended
//    pass           verdict, valid while done=1
//    sample_cnt     samples checked in the current or last run
//    err_cnt        mismatches in the current or last run
//    fail_vld       first_fail_vec holds a captured failing vector
//    first_fail_vec in_vec of the first mismatching sample
//
// Build option:
//    REDUCE_AND_CHECKER_STOP_ON_FAIL_EN  when defined, the first mismatch of
//    a run ends it immediately (pass=0). Undefined: only stop ends a run.
// ---------------------------------------------------------------------------
module reduce_and_checker #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_vec,
    input  logic             in_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             fail_vld,
    output logic [WIDTH-1:0] first_fail_vec
);

    // state   | meaning
    // --------+------------------------------------------------------
    // ST_IDLE | after reset, waiting for the first start
    // ST_RUN  | checking samples, counters updating
    // ST_DONE | run ended, verdict and counters held until next start
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic             expected;
    logic             mismatch;
    logic             take;
    logic             first_fail;
    logic             start_run;
    logic             end_run;
    logic [CNT_W-1:0] sample_nxt;
    logic [CNT_W-1:0] err_nxt;

    always_comb begin
        expected   = &in_vec;
        mismatch   = (in_out != expected);
        take       = (state == ST_RUN) && in_valid;
        // fail_vld is still clear exactly until the first mismatch of a run
        first_fail = take && mismatch && !fail_vld;

        sample_nxt = sample_cnt;
        err_nxt    = err_cnt;
        if (take && (sample_cnt != CNT_MAX)) begin
            sample_nxt = sample_cnt + 1'b1;
        end
        if (take && mismatch && (err_cnt != CNT_MAX)) begin
            err_nxt = err_cnt + 1'b1;
        end

        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // start is ignored here, so stop wins a start+stop collision
                if (stop) begin
                    state_nxt = ST_DONE;
                end
`ifdef REDUCE_AND_CHECKER_STOP_ON_FAIL_EN
                else if (first_fail) begin
                    state_nxt = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                if (start) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        start_run = (state != ST_RUN) && (state_nxt == ST_RUN);
        end_run   = (state == ST_RUN) && (state_nxt == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            sample_cnt     <= '0;
            err_cnt        <= '0;
            fail_vld       <= 1'b0;
            first_fail_vec <= '0;
        end else begin
            busy <= (state_nxt == ST_RUN);
            done <= (state_nxt == ST_DONE);
            if (start_run) begin
                pass           <= 1'b0;
                sample_cnt     <= '0;
                err_cnt        <= '0;
                fail_vld       <= 1'b0;
                first_fail_vec <= '0;
            end else begin
                // outside RUN the *_nxt values equal the current ones
                sample_cnt <= sample_nxt;
                err_cnt    <= err_nxt;
                if (first_fail) begin
                    fail_vld       <= 1'b1;
                    first_fail_vec <= in_vec;
                end
                // verdict includes a sample taken in the same cycle as stop
                if (end_run) begin
                    pass <= (err_nxt == '0) && (sample_nxt != '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_reduce_and_checker.sv
module tb_reduce_and_checker;

    localparam int WIDTH = 3;
    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;
    localparam int ONES  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic             in_valid;
    logic [WIDTH-1:0] in_vec;
    logic             in_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             fail_vld;
    logic [WIDTH-1:0] first_fail_vec;

    reduce_and_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stop           (stop),
        .in_valid       (in_valid),
        .in_vec         (in_vec),
        .in_out         (in_out),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .sample_cnt     (sample_cnt),
        .err_cnt        (err_cnt),
        .fail_vld       (fail_vld),
        .first_fail_vec (first_fail_vec)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: a run is open or closed, counts are plain integers
    bit m_running;
    bit m_finished;
    bit m_pass;
    int m_s;
    int m_e;
    bit m_fv;
    int m_ffv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model(input bit r, input bit s, input bit p, input bit v, input int vec, input bit o);
        bit want;
        bit first;
        if (r) begin
            m_running = 0; m_finished = 0; m_pass = 0;
            m_s = 0; m_e = 0; m_fv = 0; m_ffv = 0;
        end else if (!m_running && s) begin
            m_running = 1; m_finished = 0; m_pass = 0;
            m_s = 0; m_e = 0; m_fv = 0; m_ffv = 0;
        end else if (m_running) begin
            first = 0;
            if (v) begin
                want = (vec == ONES);
                if (m_s < MAXC) m_s = m_s + 1;
                if (o != want) begin
                    if (m_e < MAXC) m_e = m_e + 1;
                    if (!m_fv) begin
                        m_fv = 1; m_ffv = vec; first = 1;
                    end
                end
            end
`ifndef REDUCE_AND_CHECKER_STOP_ON_FAIL_EN
            first = 0;
`endif
            if (p || first) begin
                m_running = 0; m_finished = 1;
                m_pass = (m_e == 0) && (m_s > 0);
            end
        end
    endtask

    task automatic step(input bit r, input bit s, input bit p, input bit v,
                        input logic [WIDTH-1:0] vec, input bit o);
        rst = r; start = s; stop = p; in_valid = v; in_vec = vec; in_out = o;
        @(posedge clk);
        model(r, s, p, v, int'(vec), o);
        #1;
        chk("busy",           busy,           m_running);
        chk("done",           done,           m_finished);
        chk("pass",           pass,           m_pass);
        chk("sample_cnt",     sample_cnt,     m_s);
        chk("err_cnt",        err_cnt,        m_e);
        chk("fail_vld",       fail_vld,       m_fv);
        chk("first_fail_vec", first_fail_vec, m_ffv);
    endtask

    typedef struct {
        bit r, s, p, v;
        logic [WIDTH-1:0] vec;
        bit o;
        bit busy, done, pass;
        int scnt, ecnt;
        bit fv;
        int ffv;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit s, bit p, bit v, int vec, bit o,
                                bit b, bit d, bit ps, int sc, int ec, bit fv, int ffv);
        vec_t t;
        t.r = r; t.s = s; t.p = p; t.v = v; t.vec = vec[WIDTH-1:0]; t.o = o;
        t.busy = b; t.done = d; t.pass = ps; t.scnt = sc; t.ecnt = ec; t.fv = fv; t.ffv = ffv;
        return t;
    endfunction

    initial begin
        rst = 1; start = 0; stop = 0; in_valid = 0; in_vec = '0; in_out = 0;

        //              r s p v vec o   busy done pass scnt ecnt fv ffv
        // clean run: vectors 0,7,2,7,0,7,4 all answered correctly
        tbl.push_back(mk(1,0,0,0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,1,0,0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,0,0,1, 0, 0,  1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0,0,0,1, 7, 1,  1, 0, 0, 2, 0, 0, 0));
        tbl.push_back(mk(0,0,0,1, 2, 0,  1, 0, 0, 3, 0, 0, 0));
        tbl.push_back(mk(0,0,0,1, 7, 1,  1, 0, 0, 4, 0, 0, 0));
        tbl.push_back(mk(0,0,0,1, 0, 0,  1, 0, 0, 5, 0, 0, 0));
        tbl.push_back(mk(0,0,0,1, 7, 1,  1, 0, 0, 6, 0, 0, 0));
        tbl.push_back(mk(0,0,0,1, 4, 0,  1, 0, 0, 7, 0, 0, 0));
        tbl.push_back(mk(0,0,1,0, 0, 0,  0, 1, 1, 7, 0, 0, 0));
        // same vectors, vector 2 answered 1 and the second 7 answered 0
        tbl.push_back(mk(0,1,0,0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,0,0,1, 0, 0,  1, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0,0,0,1, 7, 1,  1, 0, 0, 2, 0, 0, 0));
`ifndef REDUCE_AND_CHECKER_STOP_ON_FAIL_EN
        tbl.push_back(mk(0,0,0,1, 2, 1,  1, 0, 0, 3, 1, 1, 2));
        tbl.push_back(mk(0,0,0,1, 7, 0,  1, 0, 0, 4, 2, 1, 2));
        tbl.push_back(mk(0,0,0,1, 0, 0,  1, 0, 0, 5, 2, 1, 2));
        tbl.push_back(mk(0,0,0,1, 7, 1,  1, 0, 0, 6, 2, 1, 2));
        tbl.push_back(mk(0,0,0,1, 4, 0,  1, 0, 0, 7, 2, 1, 2));
        tbl.push_back(mk(0,0,1,0, 0, 0,  0, 1, 0, 7, 2, 1, 2));
        tbl.push_back(mk(0,0,1,1, 2, 1,  0, 1, 0, 7, 2, 1, 2));
`else
        tbl.push_back(mk(0,0,0,1, 2, 1,  0, 1, 0, 3, 1, 1, 2));
        tbl.push_back(mk(0,0,0,1, 7, 0,  0, 1, 0, 3, 1, 1, 2));
        tbl.push_back(mk(0,0,0,1, 0, 0,  0, 1, 0, 3, 1, 1, 2));
        tbl.push_back(mk(0,0,0,1, 7, 1,  0, 1, 0, 3, 1, 1, 2));
        tbl.push_back(mk(0,0,0,1, 4, 0,  0, 1, 0, 3, 1, 1, 2));
        tbl.push_back(mk(0,0,1,0, 0, 0,  0, 1, 0, 3, 1, 1, 2));
        tbl.push_back(mk(0,0,1,1, 2, 1,  0, 1, 0, 3, 1, 1, 2));
`endif
        // start+stop in DONE: start wins; then a sample together with stop counts
        tbl.push_back(mk(0,1,1,0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,1,0,0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0,1,1,1, 7, 1,  0, 1, 1, 1, 0, 0, 0));

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].v, tbl[i].vec, tbl[i].o);
            chk($sformatf("tbl%0d.busy", i), busy,           tbl[i].busy);
            chk($sformatf("tbl%0d.done", i), done,           tbl[i].done);
            chk($sformatf("tbl%0d.pass", i), pass,           tbl[i].pass);
            chk($sformatf("tbl%0d.scnt", i), sample_cnt,     tbl[i].scnt);
            chk($sformatf("tbl%0d.ecnt", i), err_cnt,        tbl[i].ecnt);
            chk($sformatf("tbl%0d.fvld", i), fail_vld,       tbl[i].fv);
            chk($sformatf("tbl%0d.ffv",  i), first_fail_vec, tbl[i].ffv);
        end

        // saturation: 300 correct samples
        step(0, 1, 0, 0, '0, 0);
        for (int i = 0; i < 300; i++) begin
            logic [WIDTH-1:0] v;
            v = WIDTH'($urandom);
            step(0, 0, 0, 1, v, &v);
        end
        step(0, 0, 1, 0, '0, 0);
        chk("sat.scnt", sample_cnt, 255);
        chk("sat.ecnt", err_cnt, 0);
        chk("sat.pass", pass, 1);

        // reset mid-run, then an empty run
        step(0, 1, 0, 0, '0, 0);
        step(0, 0, 0, 1, 3'd7, 1);
        step(0, 0, 0, 1, 3'd1, 1);
        step(0, 0, 0, 1, 3'd5, 0);
        step(1, 1, 1, 1, 3'd6, 1);
        chk("rst.outputs", {busy, done, pass, fail_vld, first_fail_vec, sample_cnt, err_cnt}, 0);
        step(0, 0, 1, 0, '0, 0);
        chk("idle.stop_ignored", {busy, done}, 0);
        step(0, 1, 0, 0, '0, 0);
        step(0, 0, 1, 0, '0, 0);
        chk("empty.done", done, 1);
        chk("empty.pass", pass, 0);

        // stop coinciding with a mismatching 7
        step(0, 1, 0, 0, '0, 0);
        step(0, 0, 1, 1, 3'd7, 0);
        chk("stopmm.done", done, 1);
        chk("stopmm.ecnt", err_cnt, 1);
        chk("stopmm.pass", pass, 0);
        chk("stopmm.ffv",  first_fail_vec, 7);
`ifdef REDUCE_AND_CHECKER_STOP_ON_FAIL_EN
        step(0, 1, 0, 0, '0, 0);
        step(0, 0, 0, 1, 3'd3, 1);
        chk("sof.done", done, 1);
        chk("sof.ecnt", err_cnt, 1);
        chk("sof.pass", pass, 0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic [WIDTH-1:0] v;
            bit r, s, p, val, o;
            v   = WIDTH'($urandom);
            r   = ($urandom_range(0, 199) == 0);
            s   = ($urandom_range(0, 11) == 0);
            p   = ($urandom_range(0, 14) == 0);
            val = ($urandom_range(0, 2) != 0);
            o   = (&v) ^ ($urandom_range(0, 7) == 0);
            step(r, s, p, val, v, o);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
